// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : Control FSM that sequences the AES round datapath. It accepts
//               a block on a valid/ready handshake, issues the initial key-add,
//               runs one round per SubBytes latency window and presents the
//               result on an output valid/ready handshake. It drives datapath
//               enables and mux selects only; no data passes through it.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int SboxLatency = 5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [1:0] key_len_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    input  logic       clear_i,
    output logic       state_we_o,
    output logic [1:0] state_sel_o,
    output logic       sub_bytes_en_o,
    output logic       key_expand_en_o,
    output logic       mix_cols_bypass_o,
    output logic [3:0] round_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

    // Last cycle of each round's S-box window
    localparam logic [2:0] LAT_LAST = 3'(SboxLatency - 1);

    localparam logic [1:0] SEL_INPUT = 2'b00;
    localparam logic [1:0] SEL_ROUND = 2'b01;
    localparam logic [1:0] SEL_CLEAR = 2'b10;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [2:0] lat_q, lat_d;
    logic [3:0] nrounds_q, nrounds_d;
    logic       err_q, err_d;

    // State and counter registers, asynchronously reset to idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            round_q   <= 4'd0;
            lat_q     <= 3'd0;
            nrounds_q <= 4'd10;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            lat_q     <= lat_d;
            nrounds_q <= nrounds_d;
            err_q     <= err_d;
        end
    end

    // Next-state and output decode; clear_i overrides every state
    always_comb begin
        state_d           = state_q;
        round_d           = round_q;
        lat_d             = lat_q;
        nrounds_d         = nrounds_q;
        err_d             = err_q;
        in_ready_o        = 1'b0;
        out_valid_o       = 1'b0;
        state_we_o        = 1'b0;
        state_sel_o       = SEL_INPUT;
        sub_bytes_en_o    = 1'b0;
        key_expand_en_o   = 1'b0;
        mix_cols_bypass_o = 1'b0;
        round_o           = 4'd0;
        err_o             = 1'b0;

        if (clear_i) begin
            // Wipe the datapath state; nothing else may advance this cycle
            state_we_o  = 1'b1;
            state_sel_o = SEL_CLEAR;
            state_d     = S_CLEAR;
            round_d     = 4'd0;
            lat_d       = 3'd0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        if (key_len_i == 2'b11) begin
                            // Illegal key length: report an error without
                            // touching the datapath
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            case (key_len_i)
                                2'b00:   nrounds_d = 4'd10;
                                2'b01:   nrounds_d = 4'd12;
                                default: nrounds_d = 4'd14;
                            endcase
                            state_we_o      = 1'b1;
                            state_sel_o     = SEL_INPUT;
                            key_expand_en_o = 1'b1;
                            round_d         = 4'd1;
                            lat_d           = 3'd0;
                            state_d         = S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    sub_bytes_en_o = 1'b1;
                    round_o        = round_q;
                    if (lat_q == LAT_LAST) begin
                        state_we_o        = 1'b1;
                        state_sel_o       = SEL_ROUND;
                        key_expand_en_o   = 1'b1;
                        mix_cols_bypass_o = (round_q == nrounds_q);
                        lat_d             = 3'd0;
                        if (round_q == nrounds_q) begin
                            state_d = S_DONE;
                        end else begin
                            round_d = round_q + 4'd1;
                        end
                    end else begin
                        lat_d = lat_q + 3'd1;
                    end
                end
                S_DONE: begin
                    out_valid_o = 1'b1;
                    err_o       = err_q;
                    // The error path never ran a round, so it reports round 0
                    round_o     = err_q ? 4'd0 : nrounds_q;
                    if (out_ready_i) begin
                        round_d = 4'd0;
                        err_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_CLEAR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
